// File: rtl/dsc_bs2bin.sv
// Unary bitstream to binary decoder: counts the ones in each 2^SNG_WIDTH-beat frame
// and presents the count through a one-entry valid/ready output buffer.
module dsc_bs2bin #(
  parameter int SNG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bs_valid,
  input  logic                 bs_sof,
  input  logic                 bs_bit,
  output logic                 bs_ready,
  output logic                 bin_valid,
  output logic [SNG_WIDTH:0]   bin_data,
  input  logic                 bin_ready,
  output logic                 frame_err
);

  localparam int N = 1 << SNG_WIDTH;
  localparam logic [SNG_WIDTH-1:0] LAST_IDX = SNG_WIDTH'(N - 1);

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state_q, state_d;
  logic [SNG_WIDTH:0]   acc_q, acc_d;
  logic [SNG_WIDTH-1:0] idx_q, idx_d;
  logic                 bin_valid_q, bin_valid_d;
  logic [SNG_WIDTH:0]   bin_data_q, bin_data_d;
  logic                 frame_err_q, frame_err_d;
  logic                 ready_en_q;
  logic                 at_last;
  logic                 beat_acc;
  logic                 load;
  logic [SNG_WIDTH:0]   bit_ext;

  assign bit_ext  = {{SNG_WIDTH{1'b0}}, bs_bit};
  assign at_last  = (state_q == ACC) && (idx_q == LAST_IDX);
  // Stall only the closing beat while a previous result is still waiting.
  assign bs_ready = ready_en_q & ~(at_last & bin_valid_q & ~bin_ready);
  assign beat_acc = bs_valid & bs_ready;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    frame_err_d = 1'b0;
    load        = 1'b0;
    if (beat_acc) begin
      case (state_q)
        IDLE: begin
          if (bs_sof) begin
            acc_d   = bit_ext;
            idx_d   = SNG_WIDTH'(1);
            state_d = ACC;
          end else begin
            frame_err_d = 1'b1;
          end
        end
        ACC: begin
          if (bs_sof) begin
            frame_err_d = 1'b1;
            acc_d       = bit_ext;
            idx_d       = SNG_WIDTH'(1);
          end else if (idx_q == LAST_IDX) begin
            load    = 1'b1;
            acc_d   = '0;
            idx_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = acc_q + bit_ext;
            idx_d = idx_q + SNG_WIDTH'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    bin_valid_d = load | (bin_valid_q & ~bin_ready);
    bin_data_d  = load ? (acc_q + bit_ext) : bin_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      idx_q       <= '0;
      bin_valid_q <= 1'b0;
      bin_data_q  <= '0;
      frame_err_q <= 1'b0;
      ready_en_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      bin_valid_q <= bin_valid_d;
      bin_data_q  <= bin_data_d;
      frame_err_q <= frame_err_d;
      ready_en_q  <= 1'b1;
    end
  end

  assign bin_valid = bin_valid_q;
  assign bin_data  = bin_data_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_dsc_bs2bin.sv
// Scoreboard bench for dsc_bs2bin: a frame-list reference model predicts results,
// a separate monitor checks every output handshake.
module tb_dsc_bs2bin;

  localparam int W = 4;
  localparam int N = 1 << W;

  logic         clk;
  logic         rst_n;
  logic         bs_valid, bs_sof, bs_bit, bs_ready;
  logic         bin_valid, bin_ready, frame_err;
  logic [W:0]   bin_data;

  dsc_bs2bin #(.SNG_WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .bs_valid(bs_valid), .bs_sof(bs_sof), .bs_bit(bs_bit), .bs_ready(bs_ready),
    .bin_valid(bin_valid), .bin_data(bin_data), .bin_ready(bin_ready),
    .frame_err(frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  bit frame[$];
  bit exp_pending = 1'b0;
  bit exp_err = 1'b0;
  int rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus; the model advances on beats it judges accepted.
  task automatic cycle(input bit v, input bit s, input bit b, input bit r, output bit accepted);
    bit exp_ready;
    bit produce;
    int sum;
    @(negedge clk); #1;
    chk("bin_valid", bin_valid, exp_pending);
    chk("frame_err", frame_err, exp_err);
    bs_valid = v; bs_sof = s; bs_bit = b; bin_ready = r;
    #1;
    exp_ready = !(frame.size() == N - 1 && exp_pending && !r);
    chk("bs_ready", bs_ready, exp_ready);
    accepted = v && exp_ready;
    exp_err = 1'b0;
    produce = 1'b0;
    if (accepted) begin
      if (s) begin
        if (frame.size() > 0) exp_err = 1'b1;
        frame.delete();
        frame.push_back(b);
      end else if (frame.size() == 0) begin
        exp_err = 1'b1;
      end else begin
        frame.push_back(b);
        if (frame.size() == N) begin
          sum = 0;
          foreach (frame[i]) sum += frame[i];
          exp_q.push_back(sum);
          frame.delete();
          produce = 1'b1;
        end
      end
    end
    exp_pending = produce || (exp_pending && !r);
  endtask

  task automatic send_bit(input bit s, input bit b);
    bit acc;
    bit r;
    int tries;
    tries = 0;
    acc = 1'b0;
    while (!acc && tries < 64) begin
      if (rdy_mode == 0) r = 1'b1;
      else if (rdy_mode == 1) r = (tries >= 4);
      else r = 1'($urandom_range(0, 1));
      cycle(1'b1, s, b, r, acc);
      tries++;
    end
    if (!acc) chk("beat_timeout", 0, 1);
  endtask

  task automatic send_frame(input logic [N-1:0] pattern);
    for (int i = 0; i < N; i++) send_bit(i == 0, pattern[i]);
  endtask

  task automatic idle(input int n, input bit r);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, r, acc);
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    bs_valid = 1'b0; bs_sof = 1'b0; bs_bit = 1'b0;
    #1;
    chk("rst_bs_ready", bs_ready, 0);
    chk("rst_bin_valid", bin_valid, 0);
    chk("rst_bin_data", bin_data, 0);
    chk("rst_frame_err", frame_err, 0);
    frame.delete();
    exp_q.delete();
    exp_pending = 1'b0;
    exp_err = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Monitor: checks every completed output handshake against the scoreboard.
  always @(negedge clk) begin
    #3;
    if (rst_n && bin_valid && bin_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result actual=%0d required=none", bin_data);
      end else begin
        int e;
        e = exp_q.pop_front();
        $display("result bin_data=%0d expected=%0d", bin_data, e);
        chk("bin_data", bin_data, e);
      end
    end
  end

  initial begin
    bit acc;
    rst_n = 1'b1;
    bs_valid = 1'b0; bs_sof = 1'b0; bs_bit = 1'b0; bin_ready = 1'b0;
    do_reset();

    rdy_mode = 0;
    send_frame(16'h001F);
    idle(3, 1'b1);

    send_frame(16'hFFFF);
    send_frame(16'h0000);
    idle(3, 1'b1);

    rdy_mode = 1;
    send_frame(16'h007F);
    send_frame(16'h01FF);
    rdy_mode = 0;
    idle(3, 1'b1);

    for (int i = 0; i < 6; i++) send_bit(i == 0, 1'b1);
    send_frame(16'h0F0F);
    idle(2, 1'b1);

    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1, acc);
    idle(1, 1'b1);
    send_frame(16'h8001);
    idle(2, 1'b1);

    for (int i = 0; i < 8; i++) send_bit(i == 0, 1'b1);
    do_reset();
    send_frame(16'h00F0);
    idle(2, 1'b1);

    rdy_mode = 1;
    send_frame(16'h3333);
    idle(2, 1'b0);
    do_reset();
    rdy_mode = 0;
    send_frame(16'h5555);
    idle(2, 1'b1);

    for (int i = 0; i < 500; i++) begin
      bit v, s, b, r;
      v = ($urandom_range(0, 9) < 8);
      if (frame.size() == 0) s = ($urandom_range(0, 9) < 9);
      else s = ($urandom_range(0, 39) == 0);
      b = 1'($urandom_range(0, 1));
      r = ($urandom_range(0, 3) != 0);
      cycle(v, s, b, r, acc);
    end

    idle(6, 1'b1);
    chk("leftover_results", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
